rf_wb_queue: RTL

//  Write-side front end of the register file. Collects results from the load unit and the ALU through

---
 rtl/rf_wb_queue_pkg.sv | 21 ++
 rtl/rf_wb_queue_if.sv | 49 ++++
 rtl/rf_wb_fifo.sv | 60 ++++++
 rtl/rf_wb_queue.sv | 75 +++++++
 4 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared types and sizing for the register-file write-back queue.
// Holds the data/index widths, queue depth and the queued entry layout.
package rf_wb_queue_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   function automatic logic [NREG-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
      rd_onehot     = '0;
      rd_onehot[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/rf_wb_queue_if.sv
// Producer/regfile-side bundle of the write-back queue.
// RF_WB_BYPASS_EN adds the decode bypass lookup signals.
interface rf_wb_queue_if;
   import rf_wb_queue_pkg::*;

   logic              ld_valid;
   logic              ld_ready;
   logic [REG_AW-1:0] ld_rd;
   logic [XLEN-1:0]   ld_data;
   logic              alu_valid;
   logic              alu_ready;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              rf_we;
   logic [REG_AW-1:0] rf_rd;
   logic [XLEN-1:0]   rf_data;
   logic [NREG-1:0]   pending;
   logic [CNT_W-1:0]  count;

`ifdef RF_WB_BYPASS_EN
   logic [REG_AW-1:0] byp_rs1;
   logic [REG_AW-1:0] byp_rs2;
   logic              byp_hit1;
   logic              byp_hit2;
   logic [XLEN-1:0]   byp_data1;
   logic [XLEN-1:0]   byp_data2;

   modport slave (
      input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, byp_rs1, byp_rs2,
      output ld_ready, alu_ready, rf_we, rf_rd, rf_data, pending, count,
             byp_hit1, byp_hit2, byp_data1, byp_data2
   );
   modport master (
      output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, byp_rs1, byp_rs2,
      input  ld_ready, alu_ready, rf_we, rf_rd, rf_data, pending, count,
             byp_hit1, byp_hit2, byp_data1, byp_data2
   );
`else
   modport slave (
      input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
      output ld_ready, alu_ready, rf_we, rf_rd, rf_data, pending, count
   );
   modport master (
      output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
      input  ld_ready, alu_ready, rf_we, rf_rd, rf_data, pending, count
   );
`endif

endinterface

// File: rtl/rf_wb_fifo.sv
// Circular buffer of write-back entries: up to two pushes and one pop per cycle.
// Entries are exposed oldest-first so callers can scan them by age.
module rf_wb_fifo
   import rf_wb_queue_pkg::*;
#(
   parameter int ENTRIES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 push_en,
   input  wb_entry_t                  push_data0,
   input  wb_entry_t                  push_data1,
   input  logic                       pop,
   output logic [$clog2(ENTRIES):0]   count,
   output wb_entry_t                  age_entry [ENTRIES],
   output logic [ENTRIES-1:0]         age_valid
);
   localparam int AW = $clog2(ENTRIES);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr_reg, wr_ptr_reg, wr1_ptr;
   logic [CW-1:0] count_reg, count_next, push_cnt;
   logic          do_pop;
   wb_entry_t     mem_reg [ENTRIES];

   assign do_pop     = pop && (count_reg != '0);
   assign push_cnt   = CW'(push_en[0]) + CW'(push_en[1]);
   assign count_next = count_reg + push_cnt - CW'(do_pop);
   // Second push lands behind the first only when the first is present.
   assign wr1_ptr    = wr_ptr_reg + AW'(push_en[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_reg + AW'(do_pop);
         wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
         count_reg  <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en[0]) mem_reg[wr_ptr_reg] <= push_data0;
      if (push_en[1]) mem_reg[wr1_ptr]    <= push_data1;
   end

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_age
         logic [AW-1:0] age_idx;
         assign age_idx       = rd_ptr_reg + AW'(gi);
         assign age_entry[gi] = mem_reg[age_idx];
         assign age_valid[gi] = CW'(gi) < count_reg;
      end
   endgenerate

   assign count = count_reg;

endmodule

// File: rtl/rf_wb_queue.sv
// Write-side front end of the register file: load/ALU intake, in-order drain, pending scoreboard.
// Define RF_WB_BYPASS_EN to add the youngest-match bypass lookup for decode.
module rf_wb_queue
   import rf_wb_queue_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   rf_wb_queue_if.slave  bus
);
   logic [CNT_W-1:0] count, free;
   logic [1:0]       push_en;
   logic             ld_fire, alu_fire;
   wb_entry_t        ld_entry, alu_entry;
   wb_entry_t        age_entry [DEPTH];
   logic [DEPTH-1:0] age_valid;
   logic [NREG-1:0]  pending_vec;

   // Ready depends only on the registered count; the load owns the last slot.
   assign free          = CNT_W'(DEPTH) - count;
   assign bus.ld_ready  = free >= CNT_W'(1);
   assign bus.alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !bus.ld_valid);
   assign ld_fire       = bus.ld_valid && bus.ld_ready;
   assign alu_fire      = bus.alu_valid && bus.alu_ready;

   // Writes to x0 complete the handshake but are dropped here.
   assign push_en   = {alu_fire && (bus.alu_rd != '0), ld_fire && (bus.ld_rd != '0)};
   assign ld_entry  = '{rd: bus.ld_rd, data: bus.ld_data};
   assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};

   rf_wb_fifo #(.ENTRIES(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_en    (push_en),
      .push_data0 (ld_entry),
      .push_data1 (alu_entry),
      .pop        (bus.rf_we),
      .count      (count),
      .age_entry  (age_entry),
      .age_valid  (age_valid)
   );

   assign bus.rf_we   = count != '0;
   assign bus.rf_rd   = bus.rf_we ? age_entry[0].rd   : '0;
   assign bus.rf_data = bus.rf_we ? age_entry[0].data : '0;
   assign bus.count   = count;

   always_comb begin
      pending_vec = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k]) pending_vec = pending_vec | rd_onehot(age_entry[k].rd);
      end
   end
   assign bus.pending = pending_vec;

`ifdef RF_WB_BYPASS_EN
   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      bus.byp_hit1  = 1'b0;
      bus.byp_data1 = '0;
      bus.byp_hit2  = 1'b0;
      bus.byp_data2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k] && (bus.byp_rs1 != '0) && (age_entry[k].rd == bus.byp_rs1)) begin
            bus.byp_hit1  = 1'b1;
            bus.byp_data1 = age_entry[k].data;
         end
         if (age_valid[k] && (bus.byp_rs2 != '0) && (age_entry[k].rd == bus.byp_rs2)) begin
            bus.byp_hit2  = 1'b1;
            bus.byp_data2 = age_entry[k].data;
         end
      end
   end
`endif

endmodule
